// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants,
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int UART_DATA_BITS          = 8;
    localparam int UART_DEFAULT_BAUD_SCALE = 10416;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: strobes tick on the last cycle of each bit period and
// pre_tick one cycle earlier; restart re-phases the period to the current edge.
module uart_baud_tick #(
    parameter int _BAUD_SCALE = 10416
) (
    input  logic clk,
    input  logic nreset,
    input  logic restart,
    output logic tick,
    output logic pre_tick
);

    localparam int            CW   = $clog2(_BAUD_SCALE);
    localparam logic [CW-1:0] LAST = CW'(_BAUD_SCALE - 1);
    localparam logic [CW-1:0] PRE  = CW'(_BAUD_SCALE - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            cnt <= '0;
        else if (restart || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick     = (cnt == LAST);
    assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with valid/ready byte input and registered serial line.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int _BAUD_SCALE = UART_DEFAULT_BAUD_SCALE
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       txd
);

    uart_state_e state;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic        accept;
    logic        tick;
    logic        pre_tick;
`ifdef UART_TX_PARITY_EN
    logic        par;
`endif

    assign accept = tx_valid && tx_ready;

    uart_baud_tick #(
        ._BAUD_SCALE(_BAUD_SCALE)
    ) u_baud (
        .clk      (clk),
        .nreset   (nreset),
        .restart  (accept),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
            shreg    <= '0;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    shreg    <= tx_data;
                    bit_idx  <= '0;
                    txd      <= 1'b0;
                    tx_ready <= 1'b0;
                    state    <= START;
`ifdef UART_TX_PARITY_EN
                    par      <= ^tx_data;
`endif
                end
                START: if (tick) begin
                    txd   <= shreg[0];
                    shreg <= {1'b0, shreg[7:1]};
                    state <= DATA;
                end
                DATA: if (tick) begin
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                        txd     <= par;
                        state   <= PARITY;
`else
                        txd     <= 1'b1;
                        state   <= STOP;
`endif
                    end else begin
                        txd     <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (tick) begin
                    txd   <= 1'b1;
                    state <= STOP;
                end
`endif
                // Release one cycle early so a held tx_valid lands its start bit
                // exactly when the stop bit's period ends.
                STOP: if (pre_tick) begin
                    tx_ready <= 1'b1;
                    tx_done  <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    txd      <= 1'b1;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
